// File: rtl/gray_bcd_digit_assembler_if.sv
// Handshake bundle for the Gray-in / packed-BCD-out digit assembler.
// master drives digits and consumes words; slave is the assembler itself.
interface gray_bcd_digit_assembler_if #(
    parameter int DIGITS = 4
);
    logic [3:0]          in_gray;
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] out_bcd;
    logic [DIGITS-1:0]   out_bad;
    logic                out_adj_err;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output in_gray, in_valid, out_ready,
        input  in_ready, out_bcd, out_bad, out_adj_err, out_valid
    );

    modport slave (
        input  in_gray, in_valid, out_ready,
        output in_ready, out_bcd, out_bad, out_adj_err, out_valid
    );
endinterface

// File: rtl/gray_bcd_digit_assembler.sv
// Collects DIGITS Gray-coded nibbles, decodes them to binary and presents the
// packed word with per-digit >9 flags and a Gray-adjacency error flag.
module gray_bcd_digit_assembler #(
    parameter int DIGITS    = 4,
    parameter int CHECK_ADJ = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    gray_bcd_digit_assembler_if.slave   bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t              state_q,   state_d;
    logic [CW-1:0]       cnt_q,     cnt_d;
    logic [W-1:0]        asm_q,     asm_d;
    logic [DIGITS-1:0]   bad_q,     bad_d;
    logic                adj_q,     adj_d;
    logic [3:0]          prev_q,    prev_d;
    logic [W-1:0]        out_bcd_q, out_bcd_d;
    logic [DIGITS-1:0]   out_bad_q, out_bad_d;
    logic                out_adj_q, out_adj_d;

    logic [3:0]          bin;
    logic [3:0]          diff;
    logic                adj_hit;
    logic                hs;
    logic [W-1:0]        asm_shift;
    logic [DIGITS-1:0]   bad_shift;

    always_comb begin
        bin[3] = bus.in_gray[3];
        bin[2] = bin[3] ^ bus.in_gray[2];
        bin[1] = bin[2] ^ bus.in_gray[1];
        bin[0] = bin[1] ^ bus.in_gray[0];

        // The first digit of a word has no predecessor, so it is never checked.
        diff    = prev_q ^ bus.in_gray;
        adj_hit = (CHECK_ADJ != 0) && (cnt_q != '0) &&
                  !((diff != 4'd0) && ((diff & (diff - 4'd1)) == 4'd0));

        hs        = (state_q == ACCUM) && bus.in_valid;
        asm_shift = (asm_q << 4) | W'(bin);
        bad_shift = (bad_q << 1) | DIGITS'(bin > 4'd9);

        state_d   = state_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        bad_d     = bad_q;
        adj_d     = adj_q;
        prev_d    = prev_q;
        out_bcd_d = out_bcd_q;
        out_bad_d = out_bad_q;
        out_adj_d = out_adj_q;

        case (state_q)
            ACCUM: begin
                if (hs) begin
                    prev_d = bus.in_gray;
                    if (cnt_q == CW'(DIGITS - 1)) begin
                        out_bcd_d = asm_shift;
                        out_bad_d = bad_shift;
                        out_adj_d = adj_q | adj_hit;
                        asm_d     = '0;
                        bad_d     = '0;
                        adj_d     = 1'b0;
                        cnt_d     = '0;
                        state_d   = HOLD;
                    end else begin
                        asm_d = asm_shift;
                        bad_d = bad_shift;
                        adj_d = adj_q | adj_hit;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                // Word stays frozen until taken; out_bcd is left as the last word.
                if (bus.out_ready) begin
                    out_bad_d = '0;
                    out_adj_d = 1'b0;
                    state_d   = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCUM;
            cnt_q     <= '0;
            asm_q     <= '0;
            bad_q     <= '0;
            adj_q     <= 1'b0;
            prev_q    <= 4'd0;
            out_bcd_q <= '0;
            out_bad_q <= '0;
            out_adj_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            asm_q     <= asm_d;
            bad_q     <= bad_d;
            adj_q     <= adj_d;
            prev_q    <= prev_d;
            out_bcd_q <= out_bcd_d;
            out_bad_q <= out_bad_d;
            out_adj_q <= out_adj_d;
        end
    end

    assign bus.in_ready    = (state_q == ACCUM) && !rst;
    assign bus.out_valid   = (state_q == HOLD);
    assign bus.out_bcd     = out_bcd_q;
    assign bus.out_bad     = out_bad_q;
    assign bus.out_adj_err = out_adj_q;
endmodule

// File: tb/tb_gray_bcd_digit_assembler.sv
// Bench for gray_bcd_digit_assembler: a word-level reference model checked every
// cycle, plus directed words with hand-computed results (adjacency on and off).
module tb_gray_bcd_digit_assembler;
    localparam int DIGITS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    gray_bcd_digit_assembler_if #(.DIGITS(DIGITS)) if_a ();
    gray_bcd_digit_assembler_if #(.DIGITS(DIGITS)) if_b ();

    assign if_b.in_gray   = if_a.in_gray;
    assign if_b.in_valid  = if_a.in_valid;
    assign if_b.out_ready = if_a.out_ready;

    gray_bcd_digit_assembler #(.DIGITS(DIGITS), .CHECK_ADJ(1)) dut_adj (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    gray_bcd_digit_assembler #(.DIGITS(DIGITS), .CHECK_ADJ(0)) dut_noadj (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    // Reference model: tracks accepted digits as a list and builds the word arithmetically.
    bit          m_hold = 1'b0;
    logic [3:0]  m_dig[$];
    logic [15:0] m_bcd = '0;
    logic [3:0]  m_bad = '0;
    logic        m_adj = 1'b0;
    int          m_words = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_hold = 1'b0;
            m_dig.delete();
        end else if (!m_hold) begin
            if (if_a.in_valid) begin
                m_dig.push_back(if_a.in_gray);
                if (m_dig.size() == DIGITS) begin
                    m_bcd = '0;
                    m_bad = '0;
                    m_adj = 1'b0;
                    for (int i = 0; i < DIGITS; i++) begin
                        m_bcd = m_bcd * 16 + 16'(gray2bin(m_dig[i]));
                        m_bad = m_bad * 2 + 4'(gray2bin(m_dig[i]) > 4'd9);
                        if (i > 0 && $countones(m_dig[i] ^ m_dig[i-1]) != 1)
                            m_adj = 1'b1;
                    end
                    m_dig.delete();
                    m_hold = 1'b1;
                    m_words++;
                end
            end
        end else if (if_a.out_ready) begin
            m_hold = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("in_ready",    32'(if_a.in_ready),  32'(!m_hold && !rst));
            checkOutput("out_valid",   32'(if_a.out_valid), 32'(m_hold));
            checkOutput("b_in_ready",  32'(if_b.in_ready),  32'(!m_hold && !rst));
            checkOutput("b_out_valid", 32'(if_b.out_valid), 32'(m_hold));
            if (m_hold) begin
                checkOutput("out_bcd",     32'(if_a.out_bcd),     32'(m_bcd));
                checkOutput("out_bad",     32'(if_a.out_bad),     32'(m_bad));
                checkOutput("out_adj_err", 32'(if_a.out_adj_err), 32'(m_adj));
                checkOutput("b_out_bcd",   32'(if_b.out_bcd),     32'(m_bcd));
                checkOutput("b_out_bad",   32'(if_b.out_bad),     32'(m_bad));
                checkOutput("b_adj_off",   32'(if_b.out_adj_err), 32'd0);
            end
        end
    end

    // Drives one cycle of inputs and returns just after the following falling edge.
    task automatic applyStimulus(input logic v, input logic [3:0] g, input logic ordy);
        if_a.in_valid  = v;
        if_a.in_gray   = g;
        if_a.out_ready = ordy;
        @(negedge clk);
        #1;
    endtask

    task automatic sendWord(input logic [3:0] g0, input logic [3:0] g1,
                            input logic [3:0] g2, input logic [3:0] g3);
        applyStimulus(1'b1, g0, 1'b0);
        applyStimulus(1'b1, g1, 1'b0);
        applyStimulus(1'b1, g2, 1'b0);
        applyStimulus(1'b1, g3, 1'b0);
        if_a.in_valid = 1'b0;
    endtask

    task automatic expectWord(input string tag, input logic [15:0] bcd,
                              input logic [3:0] bad, input logic adj);
        checkOutput({tag, "_model_bcd"}, 32'(m_bcd), 32'(bcd));
        checkOutput({tag, "_model_bad"}, 32'(m_bad), 32'(bad));
        checkOutput({tag, "_model_adj"}, 32'(m_adj), 32'(adj));
        checkOutput({tag, "_valid"},     32'(if_a.out_valid),   32'd1);
        checkOutput({tag, "_bcd"},       32'(if_a.out_bcd),     32'(bcd));
        checkOutput({tag, "_bad"},       32'(if_a.out_bad),     32'(bad));
        checkOutput({tag, "_adj"},       32'(if_a.out_adj_err), 32'(adj));
        checkOutput({tag, "_b_adj"},     32'(if_b.out_adj_err), 32'd0);
    endtask

    task automatic releaseWord();
        applyStimulus(1'b0, 4'd0, 1'b1);
        if_a.out_ready = 1'b0;
    endtask

    initial begin
        int target;
        int budget;
        if_a.in_valid  = 1'b0;
        if_a.in_gray   = 4'd0;
        if_a.out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk_en = 1'b1;
        applyStimulus(1'b1, 4'd5, 1'b0);
        checkOutput("rst_in_ready", 32'(if_a.in_ready),    32'd0);
        checkOutput("rst_valid",    32'(if_a.out_valid),   32'd0);
        checkOutput("rst_bcd",      32'(if_a.out_bcd),     32'd0);
        checkOutput("rst_bad",      32'(if_a.out_bad),     32'd0);
        checkOutput("rst_adj",      32'(if_a.out_adj_err), 32'd0);
        if_a.in_valid = 1'b0;
        rst = 1'b0;
        applyStimulus(1'b0, 4'd0, 1'b0);

        $display("[TB] word 0123");
        sendWord(4'b0000, 4'b0001, 4'b0011, 4'b0010);
        expectWord("t1", 16'h0123, 4'b0000, 1'b0);
        releaseWord();

        $display("[TB] word 9ABC");
        sendWord(4'b1101, 4'b1111, 4'b1110, 4'b1010);
        expectWord("t2", 16'h9ABC, 4'b0111, 1'b0);
        releaseWord();

        $display("[TB] word 0221 with adjacency error, then backpressure");
        sendWord(4'b0000, 4'b0011, 4'b0011, 4'b0001);
        expectWord("t3", 16'h0221, 4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'(i % 2), 4'(i + 3), 1'b0);
            checkOutput("t4_valid", 32'(if_a.out_valid), 32'd1);
            checkOutput("t4_bcd",   32'(if_a.out_bcd),   32'h0221);
            checkOutput("t4_ready", 32'(if_a.in_ready),  32'd0);
        end
        if_a.in_valid = 1'b0;
        releaseWord();
        checkOutput("t4_valid_after", 32'(if_a.out_valid), 32'd0);
        checkOutput("t4_ready_after", 32'(if_a.in_ready),  32'd1);

        $display("[TB] reset mid-word");
        applyStimulus(1'b1, 4'b0111, 1'b0);
        applyStimulus(1'b1, 4'b0101, 1'b0);
        rst = 1'b1;
        if_a.in_valid = 1'b1;
        #1;
        checkOutput("t5_ready_in_rst", 32'(if_a.in_ready), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        sendWord(4'b0001, 4'b0011, 4'b0010, 4'b0110);
        expectWord("t5", 16'h1234, 4'b0000, 1'b0);
        releaseWord();

        $display("[TB] random gaps over 20 words");
        target = m_words + 20;
        budget = 0;
        while (m_words < target && budget < 3000) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)));
            budget++;
        end
        checkOutput("t6_words_done", 32'(m_words), 32'(target));
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 4'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
